// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment scanner: prescaled digit scan,
// double-buffered display data committed at frame end, ripple blanking, lamp test.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int DEAD_CYCLES = 1,
    parameter int HEX_MODE    = 0,
    parameter int LSD_BLANK   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic                  load_i,
    input  logic                  lt_n,
    input  logic                  bi_n,
    input  logic                  rbi_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  rbo_n,
    output logic                  frame_o
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] pend_dig, shadow_dig;
    logic [N_DIGITS-1:0]   pend_dp, shadow_dp;
    logic                  pend_valid;
    logic                  tick;

    logic [N_DIGITS-1:0]   blank;
    logic                  all_blank_req;
    logic [3:0]            nib;
    logic                  dp_cur, blank_cur;
    logic [6:0]            seg_nx;
    logic                  dp_nx, rbo_nx;
    logic [N_DIGITS-1:0]   an_nx, an_scan;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b1100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0001100;
            4'ha: g = (HEX_MODE != 0) ? 7'b0001000 : 7'b1110010;
            4'hb: g = (HEX_MODE != 0) ? 7'b1100000 : 7'b1100110;
            4'hc: g = (HEX_MODE != 0) ? 7'b0110001 : 7'b1011100;
            4'hd: g = (HEX_MODE != 0) ? 7'b1000010 : 7'b0110100;
            4'he: g = (HEX_MODE != 0) ? 7'b0110000 : 7'b1110000;
            default: g = (HEX_MODE != 0) ? 7'b0111000 : 7'b1111111;
        endcase
        return g;
    endfunction

    assign tick = (cnt == CNT_LAST);

    // Blank request ripples from the MSD down while digits stay zero.
    always_comb begin
        logic rip;
        blank = '0;
        rip   = ~rbi_n;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            blank[i] = rip & (shadow_dig[4*i +: 4] == 4'h0);
            rip      = blank[i];
        end
        all_blank_req = rip & (shadow_dig[3:0] == 4'h0);
        blank[0]      = (LSD_BLANK != 0) && all_blank_req;
    end

    always_comb begin
        nib       = 4'h0;
        dp_cur    = 1'b0;
        blank_cur = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = shadow_dig[4*i +: 4];
                dp_cur    = shadow_dp[i];
                blank_cur = blank[i];
            end
        end
    end

    always_comb begin
        an_scan = (cnt < DEAD_LIM) ? '1 : ~(N_DIGITS'(1) << idx);
        seg_nx  = blank_cur ? 7'h7F : glyph(nib);
        dp_nx   = ~dp_cur;
        an_nx   = an_scan;
        rbo_nx  = ~all_blank_req;
        if (!bi_n) begin
            seg_nx = 7'h7F;
            dp_nx  = 1'b1;
            an_nx  = '1;
            rbo_nx = 1'b0;
        end else if (!lt_n) begin
            seg_nx = 7'h00;
            dp_nx  = 1'b0;
            rbo_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= '1;
            rbo_n      <= 1'b1;
            frame_o    <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (tick && (idx == IDX_LAST) && pend_valid) begin
                shadow_dig <= pend_dig;
                shadow_dp  <= pend_dp;
                pend_valid <= 1'b0;
                frame_o    <= 1'b1;
            end
            // A load on the commit edge lands after the old data moved to shadow.
            if (load_i) begin
                pend_dig   <= digits_i;
                pend_dp    <= dp_i;
                pend_valid <= 1'b1;
            end
            seg_n <= seg_nx;
            dp_n  <= dp_nx;
            an_n  <= an_nx;
            rbo_n <= rbo_nx;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a BCD/no-LSD-blank and a hex/LSD-blank instance
// share stimulus and are compared every cycle against a time-based display model.
module tb_seg7_scan_driver;
    localparam int N = 4, SD = 4, DEAD = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_i = '0;
    logic        load_i = 1'b0, lt_n = 1'b1, bi_n = 1'b1, rbi_n = 1'b1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, rbo0, rbo1, fr0, fr1;
    logic [3:0]  an0, an1;

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .DEAD_CYCLES(DEAD), .HEX_MODE(0), .LSD_BLANK(0)) u_bcd (
        .clk(clk), .rst(rst), .digits_i(digits_i), .dp_i(dp_i), .load_i(load_i), .lt_n(lt_n),
        .bi_n(bi_n), .rbi_n(rbi_n), .seg_n(seg0), .dp_n(dp0), .an_n(an0), .rbo_n(rbo0), .frame_o(fr0));
    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .DEAD_CYCLES(DEAD), .HEX_MODE(1), .LSD_BLANK(1)) u_hex (
        .clk(clk), .rst(rst), .digits_i(digits_i), .dp_i(dp_i), .load_i(load_i), .lt_n(lt_n),
        .bi_n(bi_n), .rbi_n(rbi_n), .seg_n(seg1), .dp_n(dp1), .an_n(an1), .rbo_n(rbo1), .frame_o(fr1));

    int n_cmp = 0, n_bad = 0;

    // Model: elapsed cycles since reset fix slot and digit; buffers are plain copies.
    int          m_t = 0;
    bit          m_pv = 0;
    logic [15:0] m_pd = '0, m_sd = '0;
    logic [3:0]  m_pdp = '0, m_sdp = '0;
    logic [13:0] exp0, exp1;
    localparam logic [13:0] RESET_VEC = {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0};

    logic [6:0] bcd_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                                 7'b1100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b1110010, 7'b1100110,
                                 7'b1011100, 7'b0110100, 7'b1110000, 7'b1111111};
    logic [6:0] hex_tab [6] = '{7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    function automatic logic [13:0] got0();
        return {seg0, dp0, an0, rbo0, fr0};
    endfunction
    function automatic logic [13:0] got1();
        return {seg1, dp1, an1, rbo1, fr1};
    endfunction

    function automatic logic [12:0] ref_out(bit hexm, bit lsdb, int t, logic [15:0] dig, logic [3:0] dp,
                                            logic lt, logic bi, logic rbi);
        int cnt, idx;
        bit hz, blk;
        logic [3:0] nib, an;
        logic [6:0] seg;
        logic rbo;
        cnt = t % SD;
        idx = (t / SD) % N;
        nib = dig[idx*4 +: 4];
        hz = 1;
        for (int j = N - 1; j >= idx; j--) if (dig[j*4 +: 4] != 4'h0) hz = 0;
        blk = !rbi && hz && (idx != 0 || lsdb);
        an = (cnt < DEAD) ? 4'hF : ~(4'b0001 << idx);
        if (!bi) return {7'h7F, 1'b1, 4'hF, 1'b0};
        if (!lt) return {7'h00, 1'b0, an, 1'b1};
        if (blk) seg = 7'h7F;
        else if (hexm && nib >= 4'd10) seg = hex_tab[nib - 4'd10];
        else seg = bcd_tab[nib];
        rbo = !(!rbi && dig == 16'h0);
        return {seg, ~dp[idx], an, rbo};
    endfunction

    task automatic cyc();
        logic [12:0] o0, o1;
        bit commit;
        if (rst) begin
            m_t = 0; m_pv = 0; m_pd = '0; m_pdp = '0; m_sd = '0; m_sdp = '0;
            exp0 = RESET_VEC;
            exp1 = RESET_VEC;
        end else begin
            o0 = ref_out(0, 0, m_t, m_sd, m_sdp, lt_n, bi_n, rbi_n);
            o1 = ref_out(1, 1, m_t, m_sd, m_sdp, lt_n, bi_n, rbi_n);
            commit = (m_t % SD == SD - 1) && ((m_t / SD) % N == N - 1) && m_pv;
            if (commit) begin m_sd = m_pd; m_sdp = m_pdp; m_pv = 0; end
            if (load_i) begin m_pd = digits_i; m_pdp = dp_i; m_pv = 1; end
            exp0 = {o0, commit};
            exp1 = {o1, commit};
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        digits_i = d; dp_i = p; load_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        n_cmp += 2;
        if (got0() !== RESET_VEC) begin n_bad++; $display("FAIL reset bcd got %b want %b", got0(), RESET_VEC); end
        if (got1() !== RESET_VEC) begin n_bad++; $display("FAIL reset hex got %b want %b", got1(), RESET_VEC); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int frames = 0;
        load(16'h1234, 4'($urandom_range(0, 15)));
        cyc();
        load_i = 1'b0;
        repeat (3 * N * SD) begin
            cyc();
            frames += int'(fr0);
            n_cmp += 2;
            if (got0() !== exp0) begin n_bad++; $display("FAIL scan bcd t=%0d got %b want %b", m_t, got0(), exp0); end
            if (got1() !== exp1) begin n_bad++; $display("FAIL scan hex t=%0d got %b want %b", m_t, got1(), exp1); end
        end
        n_cmp++;
        if (frames !== 1) begin n_bad++; $display("FAIL scan_frames got %0d want 1", frames); end
    endtask

    task automatic test_ripple();
        logic [15:0] pats [2] = '{16'h0050, 16'h0000};
        rbi_n = 1'b0;
        foreach (pats[k]) begin
            load(pats[k], 4'($urandom_range(0, 15)));
            cyc();
            load_i = 1'b0;
            repeat (2 * N * SD) begin
                cyc();
                n_cmp += 2;
                if (got0() !== exp0) begin n_bad++; $display("FAIL ripple bcd t=%0d got %b want %b", m_t, got0(), exp0); end
                if (got1() !== exp1) begin n_bad++; $display("FAIL ripple hex t=%0d got %b want %b", m_t, got1(), exp1); end
            end
        end
        rbi_n = 1'b1;
    endtask

    task automatic test_glyphs();
        logic [15:0] pats [3] = '{16'hABCD, 16'hEF09, 16'h5678};
        foreach (pats[k]) begin
            load(pats[k], 4'($urandom_range(0, 15)));
            cyc();
            load_i = 1'b0;
            repeat (2 * N * SD) begin
                cyc();
                n_cmp += 2;
                if (got0() !== exp0) begin n_bad++; $display("FAIL glyph bcd t=%0d got %b want %b", m_t, got0(), exp0); end
                if (got1() !== exp1) begin n_bad++; $display("FAIL glyph hex t=%0d got %b want %b", m_t, got1(), exp1); end
            end
        end
    endtask

    task automatic test_lamp_blank();
        lt_n = 1'b0;
        repeat (N * SD) begin
            cyc();
            n_cmp += 2;
            if (got0() !== exp0) begin n_bad++; $display("FAIL lamp bcd t=%0d got %b want %b", m_t, got0(), exp0); end
            if (got1() !== exp1) begin n_bad++; $display("FAIL lamp hex t=%0d got %b want %b", m_t, got1(), exp1); end
        end
        bi_n = 1'b0;
        repeat (N * SD) begin
            cyc();
            n_cmp += 2;
            if (got0() !== exp0) begin n_bad++; $display("FAIL blank bcd t=%0d got %b want %b", m_t, got0(), exp0); end
            if (got1() !== exp1) begin n_bad++; $display("FAIL blank hex t=%0d got %b want %b", m_t, got1(), exp1); end
        end
        lt_n = 1'b1; bi_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int frames = 0;
        while (!((m_t % SD == SD - 1) && ((m_t / SD) % N == N - 1))) cyc();
        cyc();
        load(16'h5555, 4'b0101);
        cyc();
        load_i = 1'b0;
        while (!((m_t % SD == SD - 1) && ((m_t / SD) % N == N - 1))) begin
            cyc();
            frames += int'(fr0);
            n_cmp += 2;
            if (got0() !== exp0) begin n_bad++; $display("FAIL b2b_pre bcd t=%0d got %b want %b", m_t, got0(), exp0); end
            if (got1() !== exp1) begin n_bad++; $display("FAIL b2b_pre hex t=%0d got %b want %b", m_t, got1(), exp1); end
        end
        load(16'h9999, 4'b1010);
        repeat (2 * N * SD + 2) begin
            cyc();
            load_i = 1'b0;
            frames += int'(fr0);
            n_cmp += 2;
            if (got0() !== exp0) begin n_bad++; $display("FAIL b2b bcd t=%0d got %b want %b", m_t, got0(), exp0); end
            if (got1() !== exp1) begin n_bad++; $display("FAIL b2b hex t=%0d got %b want %b", m_t, got1(), exp1); end
        end
        n_cmp++;
        if (frames !== 2) begin n_bad++; $display("FAIL b2b_frames got %0d want 2", frames); end
    endtask

    task automatic test_reset_mid();
        int frames = 0;
        while (!((m_t % SD == SD - 1) && ((m_t / SD) % N == N - 1))) cyc();
        cyc();
        load(16'h7777, 4'hF);
        cyc();
        load_i = 1'b0;
        while (!(((m_t / SD) % N == 2) && (m_t % SD == 1))) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp += 2;
        if (got0() !== RESET_VEC) begin n_bad++; $display("FAIL rst_mid bcd got %b want %b", got0(), RESET_VEC); end
        if (got1() !== RESET_VEC) begin n_bad++; $display("FAIL rst_mid hex got %b want %b", got1(), RESET_VEC); end
        repeat (2 * N * SD) begin
            cyc();
            frames += int'(fr0);
            n_cmp += 2;
            if (got0() !== exp0) begin n_bad++; $display("FAIL rst_after bcd t=%0d got %b want %b", m_t, got0(), exp0); end
            if (got1() !== exp1) begin n_bad++; $display("FAIL rst_after hex t=%0d got %b want %b", m_t, got1(), exp1); end
        end
        n_cmp++;
        if (frames !== 0) begin n_bad++; $display("FAIL rst_frames got %0d want 0", frames); end
    endtask

    task automatic test_random();
        repeat (600) begin
            load_i   = ($urandom_range(0, 9) == 0);
            digits_i = 16'($urandom);
            if ($urandom_range(0, 1) == 0) digits_i[15:8] = 8'h00;
            dp_i     = 4'($urandom_range(0, 15));
            rbi_n    = 1'($urandom_range(0, 1));
            lt_n     = ($urandom_range(0, 7) != 0);
            bi_n     = ($urandom_range(0, 11) != 0);
            cyc();
            n_cmp += 2;
            if (got0() !== exp0) begin n_bad++; $display("FAIL random bcd t=%0d got %b want %b", m_t, got0(), exp0); end
            if (got1() !== exp1) begin n_bad++; $display("FAIL random hex t=%0d got %b want %b", m_t, got1(), exp1); end
        end
        load_i = 1'b0; lt_n = 1'b1; bi_n = 1'b1; rbi_n = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_scan();
        test_ripple();
        test_glyphs();
        test_lamp_blank();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
